// File: rtl/sa_intr_aggregator.sv
// Interrupt aggregation stage: per-source sticky status with edge/level capture,
// masking, write-1-to-clear, a registered interrupt line and a saturating event counter.
module sa_intr_aggregator #(
    parameter int NSRC    = 8,
    parameter int SYNC_EN = 1,
    parameter int CNT_W   = 8
) (
    input  logic             autosa_core_clk,
    input  logic             autosa_core_rstn,
    input  logic [NSRC-1:0]  src_req,
    input  logic [NSRC-1:0]  cfg_edge,
    input  logic [NSRC-1:0]  cfg_mask,
    input  logic             clr_valid,
    input  logic [NSRC-1:0]  clr_bits,
    input  logic             cnt_clr,
    output logic [NSRC-1:0]  status,
    output logic             intr_out,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             evt_ovf
);

    localparam logic [CNT_W+5:0] SAT_VAL = {6'd0, {CNT_W{1'b1}}};

    logic [NSRC-1:0]  req_s;
    logic [NSRC-1:0]  req_hist_q;
    logic [NSRC-1:0]  hit_s;
    logic [NSRC-1:0]  new_s;
    logic [NSRC-1:0]  clr_mask_s;
    logic [NSRC-1:0]  status_q, status_d;
    logic             intr_q, intr_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             evt_ovf_q, evt_ovf_d;
    logic [5:0]       new_cnt_s;
    logic [CNT_W+5:0] sum_s;

    if (SYNC_EN != 0) begin : g_sync
        logic [NSRC-1:0] sync1_q;
        logic [NSRC-1:0] sync2_q;

        // Two-flop synchronizer on every request line
        always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
            if (!autosa_core_rstn) begin
                sync1_q <= {NSRC{1'b0}};
                sync2_q <= {NSRC{1'b0}};
            end else begin
                sync1_q <= src_req;
                sync2_q <= sync1_q;
            end
        end

        assign req_s = sync2_q;
    end else begin : g_nosync
        assign req_s = src_req;
    end

    // Capture, clear, interrupt and counter next-state
    always_comb begin
        hit_s = req_s & (~cfg_edge | ~req_hist_q);
        if (clr_valid) begin
            clr_mask_s = clr_bits;
        end else begin
            clr_mask_s = {NSRC{1'b0}};
        end
        // Set takes precedence over a simultaneous clear
        status_d = hit_s | (status_q & ~clr_mask_s);
        intr_d   = |(status_d & ~cfg_mask);

        new_s     = hit_s & ~status_q;
        new_cnt_s = 6'd0;
        for (int i = 0; i < NSRC; i++) begin
            new_cnt_s = new_cnt_s + {5'd0, new_s[i]};
        end
        sum_s = {6'd0, evt_cnt_q} + {{CNT_W{1'b0}}, new_cnt_s};

        if (cnt_clr) begin
            evt_cnt_d = {CNT_W{1'b0}};
            evt_ovf_d = 1'b0;
        end else if (sum_s >= SAT_VAL) begin
            evt_cnt_d = {CNT_W{1'b1}};
            evt_ovf_d = 1'b1;
        end else begin
            evt_cnt_d = sum_s[CNT_W-1:0];
            evt_ovf_d = evt_ovf_q;
        end
    end

    // State and output registers
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            req_hist_q <= {NSRC{1'b0}};
            status_q   <= {NSRC{1'b0}};
            intr_q     <= 1'b0;
            evt_cnt_q  <= {CNT_W{1'b0}};
            evt_ovf_q  <= 1'b0;
        end else begin
            req_hist_q <= req_s;
            status_q   <= status_d;
            intr_q     <= intr_d;
            evt_cnt_q  <= evt_cnt_d;
            evt_ovf_q  <= evt_ovf_d;
        end
    end

    assign status   = status_q;
    assign intr_out = intr_q;
    assign evt_cnt  = evt_cnt_q;
    assign evt_ovf  = evt_ovf_q;

endmodule

// File: tb/tb_sa_intr_aggregator.sv
// Directed bench: one synchronized instance (a) and one unsynchronized instance (b),
// sharing clock and reset, each checked against hand-computed values.
module tb_sa_intr_aggregator;

    logic       clk;
    logic       rstn;
    logic [7:0] src_a, edge_a, mask_a, clrb_a, status_a, evt_cnt_a;
    logic       clrv_a, cntclr_a, intr_a, ovf_a;
    logic [7:0] src_b, edge_b, mask_b, clrb_b, status_b, evt_cnt_b;
    logic       clrv_b, cntclr_b, intr_b, ovf_b;

    int n_vec;
    int n_err;

    sa_intr_aggregator #(.NSRC(8), .SYNC_EN(1), .CNT_W(8)) u_dut_a (
        .autosa_core_clk (clk),
        .autosa_core_rstn(rstn),
        .src_req         (src_a),
        .cfg_edge        (edge_a),
        .cfg_mask        (mask_a),
        .clr_valid       (clrv_a),
        .clr_bits        (clrb_a),
        .cnt_clr         (cntclr_a),
        .status          (status_a),
        .intr_out        (intr_a),
        .evt_cnt         (evt_cnt_a),
        .evt_ovf         (ovf_a)
    );

    sa_intr_aggregator #(.NSRC(8), .SYNC_EN(0), .CNT_W(8)) u_dut_b (
        .autosa_core_clk (clk),
        .autosa_core_rstn(rstn),
        .src_req         (src_b),
        .cfg_edge        (edge_b),
        .cfg_mask        (mask_b),
        .clr_valid       (clrv_b),
        .clr_bits        (clrb_b),
        .cnt_clr         (cntclr_b),
        .status          (status_b),
        .intr_out        (intr_b),
        .evt_cnt         (evt_cnt_b),
        .evt_ovf         (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec = n_vec + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn = 1'b0;
        src_a = 8'h00; edge_a = 8'h00; mask_a = 8'h00; clrb_a = 8'h00; clrv_a = 1'b0; cntclr_a = 1'b0;
        src_b = 8'h00; edge_b = 8'h00; mask_b = 8'h00; clrb_b = 8'h00; clrv_b = 1'b0; cntclr_b = 1'b0;
        tick(3);
        chk("rst_status", {24'd0, status_a}, 32'h0);
        chk("rst_intr", {31'd0, intr_a}, 32'h0);
        chk("rst_cnt", {24'd0, evt_cnt_a}, 32'h0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick(1);

        // Reset mid-operation on instance b (level mode)
        src_b = 8'h01; cntclr_b = 1'b1;
        tick(1);
        cntclr_b = 1'b0; src_b = 8'hA5;
        tick(1);
        src_b = 8'h00;
        chk("pre_rst_status", {24'd0, status_b}, 32'hA5);
        chk("pre_rst_intr", {31'd0, intr_b}, 32'h1);
        chk("pre_rst_cnt", {24'd0, evt_cnt_b}, 32'h3);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_status", {24'd0, status_b}, 32'h0);
        chk("async_rst_intr", {31'd0, intr_b}, 32'h0);
        chk("async_rst_cnt", {24'd0, evt_cnt_b}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick(2);
        chk("post_rst_status", {24'd0, status_b}, 32'h0);
        chk("post_rst_intr", {31'd0, intr_b}, 32'h0);

        // Edge capture through the synchronizer, 5-cycle pulse on src[2]
        edge_a = 8'hFF;
        src_a = 8'h04;
        tick(2);
        chk("edge_lat2_intr", {31'd0, intr_a}, 32'h0);
        tick(1);
        chk("edge_lat3_status", {24'd0, status_a}, 32'h04);
        chk("edge_lat3_intr", {31'd0, intr_a}, 32'h1);
        tick(2);
        src_a = 8'h00;
        tick(3);
        chk("edge_cnt_once", {24'd0, evt_cnt_a}, 32'h1);
        clrv_a = 1'b1; clrb_a = 8'h04;
        tick(1);
        clrv_a = 1'b0; clrb_a = 8'h00;
        chk("edge_clr_status", {24'd0, status_a}, 32'h0);
        chk("edge_clr_intr", {31'd0, intr_a}, 32'h0);

        // Clear vs set collision, level mode
        edge_a = 8'h00;
        src_a = 8'h01;
        tick(3);
        chk("lvl_status", {24'd0, status_a}, 32'h01);
        clrv_a = 1'b1; clrb_a = 8'h01;
        tick(1);
        clrv_a = 1'b0;
        chk("set_wins", {24'd0, status_a}, 32'h01);
        src_a = 8'h00;
        tick(2);
        clrv_a = 1'b1;
        tick(1);
        clrv_a = 1'b0; clrb_a = 8'h00;
        chk("lvl_clr_status", {24'd0, status_a}, 32'h0);
        chk("lvl_clr_intr", {31'd0, intr_a}, 32'h0);
        chk("rehit_not_counted", {24'd0, evt_cnt_a}, 32'h2);

        // Masking
        mask_a = 8'h10;
        src_a = 8'h10;
        tick(3);
        chk("mask_status", {24'd0, status_a}, 32'h10);
        chk("mask_intr", {31'd0, intr_a}, 32'h0);
        mask_a = 8'h00;
        tick(1);
        chk("unmask_intr", {31'd0, intr_a}, 32'h1);
        chk("unmask_status", {24'd0, status_a}, 32'h10);
        src_a = 8'h00;
        tick(2);
        clrv_a = 1'b1; clrb_a = 8'hFF;
        tick(1);
        chk("mask_cnt", {24'd0, evt_cnt_a}, 32'h3);

        // Saturation: 300 single-bit set/clear events on bit 0
        clrb_a = 8'h01;
        for (int k = 0; k < 600; k++) begin
            src_a = (k % 2 == 0) ? 8'h01 : 8'h00;
            tick(1);
        end
        src_a = 8'h00;
        tick(3);
        chk("sat_cnt", {24'd0, evt_cnt_a}, 32'hFF);
        chk("sat_ovf", {31'd0, ovf_a}, 32'h1);
        src_a = 8'h01;
        tick(2);
        cntclr_a = 1'b1;
        tick(1);
        cntclr_a = 1'b0;
        chk("cntclr_cnt", {24'd0, evt_cnt_a}, 32'h0);
        chk("cntclr_ovf", {31'd0, ovf_a}, 32'h0);
        chk("cntclr_status", {24'd0, status_a}, 32'h01);
        tick(1);
        chk("cntclr_discard", {24'd0, evt_cnt_a}, 32'h0);
        clrv_a = 1'b0;

        // Multi-hit on instance b from evt_cnt = 250
        for (int k = 0; k < 32; k++) begin
            src_b = (k == 31) ? 8'h03 : 8'hFF;
            clrv_b = 1'b0;
            tick(1);
            src_b = 8'h00; clrv_b = 1'b1; clrb_b = 8'hFF;
            tick(1);
        end
        clrv_b = 1'b0;
        chk("pre_multi_cnt", {24'd0, evt_cnt_b}, 32'd250);
        chk("pre_multi_ovf", {31'd0, ovf_b}, 32'h0);
        chk("pre_multi_intr", {31'd0, intr_b}, 32'h0);
        edge_b = 8'hFF;
        src_b = 8'hFF;
        tick(1);
        chk("multi_cnt", {24'd0, evt_cnt_b}, 32'hFF);
        chk("multi_ovf", {31'd0, ovf_b}, 32'h1);
        chk("multi_status", {24'd0, status_b}, 32'hFF);
        chk("multi_intr", {31'd0, intr_b}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
